// File: rtl/jpeg_rd_pkg.sv
// Shared types and marker constants for the JPEG frame-memory reader.
package jpeg_rd_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDrain
  } state_e;

  localparam logic [7:0] JPEG_MARK = 8'hFF;
  localparam logic [7:0] JPEG_EOI  = 8'hD9;

endpackage

// File: rtl/jpeg_data_reader_if.sv
// Control, RAM read port and byte-stream signals of the JPEG reader.
interface jpeg_data_reader_if #(
  parameter int unsigned ADDR_W = 17
);
  logic              start;
  logic [ADDR_W-1:0] len;
  logic              rd_en;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        mem_data;
  logic              out_valid;
  logic [7:0]        out_data;
  logic              out_ready;
  logic              busy;
  logic              done;

  // master: the reader; slave: host/RAM side
  modport master (
    input  start, len, mem_data, out_ready,
    output rd_en, addr, out_valid, out_data, busy, done
  );

  modport slave (
    output start, len, mem_data, out_ready,
    input  rd_en, addr, out_valid, out_data, busy, done
  );
endinterface

// File: rtl/jpeg_rd_skid_fifo.sv
// Two-entry byte FIFO absorbing the RAM read latency; flush wins over push/pop.
module jpeg_rd_skid_fifo (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic       flush_i,
  input  logic [7:0] data_i,
  output logic [1:0] count_o,
  output logic [7:0] head_o
);

  logic [7:0] mem_q [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push_i) wr_ptr_d = ~wr_ptr_q;
      if (pop_i)  rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= 8'h00;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/jpeg_data_reader.sv
// Streams len bytes from frame memory address 0 upward onto a valid/ready byte
// stream, optionally stopping once an FF D9 end-of-image pair has been delivered.
module jpeg_data_reader
  import jpeg_rd_pkg::*;
#(
  parameter int unsigned ADDR_W   = 17,
  parameter int unsigned EOI_STOP = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  jpeg_data_reader_if.master  bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] issued_q, issued_d;
  logic [ADDR_W-1:0] issued_inc;
  logic              inflight_q, inflight_d;
  logic              mark_q, mark_d;
  logic              zdone_q, zdone_d;

  logic [1:0] fifo_count;
  logic [7:0] fifo_head;
  logic       out_valid;
  logic       pop;
  logic       push;
  logic       eoi_hit;
  logic       issue;
  logic [2:0] occ;

  assign out_valid  = (fifo_count != 2'd0);
  assign pop        = out_valid && bus.out_ready;
  // FF followed by D9 on the stream: stop issuing and drop everything not yet delivered
  assign eoi_hit    = (EOI_STOP != 0) && pop && mark_q && (fifo_head == JPEG_EOI);
  assign push       = inflight_q && !eoi_hit;
  assign occ        = {1'b0, fifo_count} + {2'b00, inflight_q};
  assign issued_inc = issued_q + 1'b1;
  assign issue      = (state_q == StFetch) && (issued_q < len_q) &&
                      (occ < (3'd2 + {2'b00, pop})) && !eoi_hit;

  jpeg_rd_skid_fifo u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (eoi_hit),
    .data_i  (bus.mem_data),
    .count_o (fifo_count),
    .head_o  (fifo_head)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    issued_d   = issued_q;
    inflight_d = issue;
    mark_d     = mark_q;
    zdone_d    = 1'b0;

    if (pop) mark_d = (fifo_head == JPEG_MARK);

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (bus.len != '0) begin
            state_d  = StFetch;
            len_d    = bus.len;
            issued_d = '0;
            mark_d   = 1'b0;
          end else begin
            zdone_d = 1'b1;
          end
        end
      end
      StFetch: begin
        if (issue) begin
          issued_d = issued_inc;
          if (issued_inc == len_q) state_d = StDrain;
        end
        if (eoi_hit) state_d = StDrain;
      end
      StDrain: begin
        if ((fifo_count == 2'd0) && !inflight_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      len_q      <= '0;
      issued_q   <= '0;
      inflight_q <= 1'b0;
      mark_q     <= 1'b0;
      zdone_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      inflight_q <= inflight_d;
      mark_q     <= mark_d;
      zdone_q    <= zdone_d;
    end
  end

  assign bus.rd_en     = issue;
  assign bus.addr      = issued_q;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = fifo_head;
  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = ((state_q == StDrain) && (fifo_count == 2'd0) && !inflight_q) || zdone_q;

endmodule

// File: tb/tb_jpeg_data_reader.sv
// Scoreboard bench for jpeg_data_reader: a byte-list model fills an expectation
// queue at each start; a negedge monitor checks every transfer, stall and done.
module tb_jpeg_data_reader;
  localparam int unsigned AW = 17;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  jpeg_data_reader_if #(.ADDR_W(AW)) bus ();

  jpeg_data_reader #(.ADDR_W(AW), .EOI_STOP(1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [7:0] mem [256];
  logic [7:0] exp_q [$];
  int checks = 0, errors = 0;
  int exp_done = 0, done_cnt = 0, rd_cnt = 0, acc_cnt = 0, rd_total = 0;
  int ready_mode = 0;  // 0: always ready, 1: random, 2: never ready
  bit want_done = 0, prev_stall = 0;
  logic [7:0] prev_data;

  function automatic void check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endfunction

  // synchronous RAM, one-cycle read latency
  initial forever begin
    @(posedge clk);
    if (bus.rd_en) bus.mem_data <= mem[bus.addr[7:0]];
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = 1'($urandom_range(0, 1));
      default: bus.out_ready = 1'b0;
    endcase
  end

  // monitor / scoreboard
  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      prev_stall = 0;
      want_done  = 0;
      rd_cnt     = 0;
      acc_cnt    = 0;
    end else begin
      if (want_done) begin
        check("done_after_last", bus.done, 1);
        want_done = 0;
      end
      if (prev_stall) begin
        check("stall_valid", bus.out_valid, 1);
        check("stall_data", bus.out_data, prev_data);
      end
      if (!bus.busy) begin
        rd_cnt  = 0;
        acc_cnt = 0;
      end
      if (bus.rd_en) begin
        check("rd_addr", bus.addr, rd_cnt);
        rd_cnt++;
        rd_total++;
      end
      if (bus.out_valid && bus.out_ready) begin
        acc_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %0h expected none at %0t", bus.out_data, $time);
        end else begin
          check("byte", bus.out_data, exp_q.pop_front());
          if (exp_q.size() == 0) want_done = 1;
        end
      end
      if (bus.busy) check("outstanding_le2", (rd_cnt - acc_cnt) <= 2, 1);
      if (bus.done) begin
        done_cnt++;
        check("done_expected", exp_done > 0, 1);
        check("done_queue_empty", exp_q.size(), 0);
        if (exp_done > 0) exp_done--;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
    end
  end

  // Model: bytes in address order, cut after the first FF D9 pair.
  task automatic start_stream(input int l, input bit accept);
    if (accept) begin
      exp_done++;
      for (int i = 0; i < l; i++) begin
        exp_q.push_back(mem[i]);
        if (i > 0 && mem[i-1] == 8'hFF && mem[i] == 8'hD9) break;
      end
    end
    bus.start = 1'b1;
    bus.len   = AW'(l);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!(bus.done === 1'b1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (bus.done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done within %0d cycles", budget);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"}, bus.rd_en, 0);
    check({tag, "_addr"}, bus.addr, 0);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_out_data"}, bus.out_data, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
  endtask

  initial begin
    int t0, d0, n;
    bus.start = 1'b0;
    bus.len   = '0;
    fill_ramp();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // ramp, always ready: exact latency
    t0 = rd_total;
    start_stream(16, 1);
    @(negedge clk);
    check("t1_busy", bus.busy, 1);
    check("t1_rd_en", bus.rd_en, 1);
    check("t1_valid_e0", bus.out_valid, 0);
    @(negedge clk);
    check("t1_valid_e1", bus.out_valid, 0);
    @(negedge clk);
    check("t1_valid_e2", bus.out_valid, 1);
    check("t1_first", bus.out_data, 8'h00);
    wait_done(40);
    check("t1_reads", rd_total - t0, 16);
    check("t1_idle", bus.busy, 0);

    // full back-pressure then release
    ready_mode = 2;
    t0 = rd_total;
    start_stream(12, 1);
    repeat (8) @(posedge clk);
    #1;
    check("bp_reads", rd_total - t0, 2);
    check("bp_valid", bus.out_valid, 1);
    ready_mode = 0;
    @(posedge clk);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("bp_no_bubble", bus.out_valid, 1);
    end
    @(posedge clk);
    #1;
    wait_done(40);

    // ramp, random ready
    ready_mode = 1;
    start_stream(16, 1);
    wait_done(200);

    // len = 0
    ready_mode = 0;
    t0 = rd_total;
    start_stream(0, 1);
    @(negedge clk);
    check("z_done", bus.done, 1);
    check("z_busy", bus.busy, 0);
    @(negedge clk);
    check("z_done_once", bus.done, 0);
    check("z_busy2", bus.busy, 0);
    check("z_reads", rd_total - t0, 0);
    @(posedge clk);
    #1;

    // EOI stop: AA/BB must never appear
    ready_mode = 1;
    for (int i = 0; i < 256; i++) mem[i] = 8'h55;
    mem[0] = 8'hFF; mem[1] = 8'hD8; mem[2] = 8'h12; mem[3] = 8'hFF;
    mem[4] = 8'hD9; mem[5] = 8'hAA; mem[6] = 8'hBB;
    d0 = done_cnt;
    start_stream(11, 1);
    wait_done(200);
    repeat (4) @(posedge clk);
    #1;
    check("eoi_one_done", done_cnt - d0, 1);

    // isolated D9 does not stop
    mem[0] = 8'h00; mem[1] = 8'hD9; mem[2] = 8'h05; mem[3] = 8'hFF;
    mem[4] = 8'h07; mem[5] = 8'hD9; mem[6] = 8'h33; mem[7] = 8'h44;
    start_stream(8, 1);
    wait_done(200);

    // start while busy is ignored
    fill_ramp();
    ready_mode = 0;
    d0 = done_cnt;
    start_stream(8, 1);
    repeat (2) @(posedge clk);
    #1;
    start_stream(3, 0);
    wait_done(40);
    repeat (5) @(posedge clk);
    #1;
    check("busy_start_one_done", done_cnt - d0, 1);

    // reset mid-stream
    start_stream(10, 1);
    n = 0;
    while (acc_cnt < 5 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("pre_reset_progress", acc_cnt >= 5, 1);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    exp_q.delete();
    exp_done = 0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    start_stream(4, 1);
    wait_done(40);

    // randomized streams with sprinkled markers
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 256; i++) begin
        n = int'($urandom_range(0, 9));
        mem[i] = (n == 0) ? 8'hFF : (n == 1) ? 8'hD9 : 8'($urandom);
      end
      ready_mode = int'($urandom_range(0, 1));
      start_stream(int'($urandom_range(1, 40)), 1);
      wait_done(400);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    check("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jpeg_data_reader.md
# jpeg_data_reader

Streams a compressed JPEG image back out of the frame memory that `jpeg_data_writer` filled. On a start pulse it reads `len` bytes from address 0 upward. Reads use a synchronous single-port RAM read port with 1-cycle latency. Bytes are presented on a valid/ready byte stream toward the host link (UART/SPI bridge). A 2-entry output buffer absorbs RAM latency, so the stream sustains 1 byte/cycle under full back-pressure tolerance.

## Interface
- `ADDR_W`, 17, memory address width; matches writer `addr`.
- `EOI_STOP`, 1, when 1, end the stream after the byte pair FF D9 is delivered, even if `len` is not reached.
- `clk` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle request; ignored unless idle.
- `len` in ADDR_W: byte count to read; sampled only on an accepted `start`.
- `rd_en` out 1: RAM read strobe.
- `addr` out ADDR_W: RAM read address, valid with `rd_en`.
- `mem_data` in 8: RAM read data, valid the cycle after `rd_en`.
- `out_valid` out 1: `out_data` holds a byte.
- `out_data` out 8: stream byte.
- `out_ready` in 1: sink accepts the byte.
- `busy` out 1: high from accepted `start` until `done`.
- `done` out 1: single-cycle end-of-stream pulse.

## Operation
- States: IDLE, FETCH, DRAIN.
- IDLE -> FETCH on `start` with `len` != 0. Captures `len`, clears the issue counter and EOI tracker.
- `start` with `len` == 0 produces no reads. `done` pulses the next cycle and the block stays in IDLE.
- FETCH issues a read (`rd_en`=1, `addr`=issue count, then increment) whenever issued < len and (buffer occupancy + in-flight − pop_this_cycle) < 2.
- FETCH -> DRAIN when the final read issues (issued == len after the increment).
- DRAIN -> IDLE when the buffer is empty and nothing is in flight; `done` pulses on that transition.
- A transfer is `out_valid` && `out_ready`. `out_data` and `out_valid` must hold stable while `out_valid` && !`out_ready`.
- Bytes are delivered in address order, none duplicated or dropped.
- EOI (only if `EOI_STOP`=1):
  - The tracker records whether the last transferred byte was FF.
  - A transfer of D9 immediately following a transferred FF stops further issue.
  - It also discards buffered and in-flight bytes; a returning in-flight byte is not written.
  - `done` pulses the cycle after the D9 transfer, then the block returns to IDLE.
- `start` while `busy` is ignored, with no effect on `len` or the counters.
- Address never wraps: the last address issued is `len`−1; `len` up to 2^ADDR_W−1.

## Timing
- Reset values: `rd_en`=0, `addr`=0, `out_valid`=0, `out_data`=00, `busy`=0, `done`=0, state IDLE, buffer empty.
- Reset asserted mid-stream clears everything immediately, with no `done`.
- Accepted `start` at edge E0:
  - `busy`=1 and the first `rd_en` (addr 0) during cycle E0→E1.
  - Data captured into the buffer at E2; `out_valid`=1 after E2.
  - Latency is therefore 2 cycles.
- With `out_ready` held at 1: one transfer per cycle. The last byte transfers at E(len+1); `done`=1 in the following cycle.
- Back-pressure: with `out_ready`=0 at most 2 bytes are buffered and no reads issue. Release resumes 1 byte/cycle with no bubble.
- `done` and `busy` fall together. `start` is accepted in the same cycle `done` is high only if the state is already IDLE (i.e. the next cycle).

## Structure
- Package `jpeg_rd_pkg`: state enum (IDLE/FETCH/DRAIN), constants `JPEG_MARK`=8'hFF, `JPEG_EOI`=8'hD9.
- Sub-module `jpeg_rd_skid_fifo`: 2-entry byte FIFO with push/pop/flush, `count[1:0]`, head output.
- Top holds the FSM, issue counter, in-flight flag, and EOI tracker.

## Test plan
- RAM preloaded with bytes = addr[7:0], `len`=16, `out_ready`=1 → out_valid at start+2, bytes 00..0F on consecutive cycles, `done` 1 cycle after 0F, 16 `rd_en` pulses total.
- Same data, `out_ready` random 50% → identical 00..0F sequence. Scoreboard shows `out_data` stable while stalled and never more than 2 reads outstanding beyond accepted bytes.
- `len`=0 start → no `rd_en`; `done` next cycle; `busy` never high.
- `EOI_STOP`=1, memory FF D8 .. 12 FF D9 AA BB at addresses 0..N, `len`=N+5 → stream ends with FF D9. AA/BB are never presented; `done` the cycle after the D9 transfer. Also check that an isolated D9 not preceded by FF does not stop the stream.
- Second `start` (`len`=3) pulsed mid-stream of `len`=8 → ignored; exactly 8 bytes then one `done`.
- `reset_n` dropped after 5 of 10 bytes → all outputs at reset values asynchronously. A fresh `start` with `len`=4 then delivers addresses 0..3.
